// File: rtl/axi4_lite_master_arbiter_pkg.sv
// Shared AXI4-Lite constants: response codes, arbiter FSM states and requester count.
package axi4_lite_master_arbiter_pkg;

   localparam int unsigned N_REQ = 2;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef axi_resp_e axi_rresp_e;
   typedef axi_resp_e axi_bresp_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW_W,
      ST_B,
      ST_RESP
   } arb_state_e;

endpackage

// File: rtl/axi4_lite_master_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module rr_arbiter2
   import axi4_lite_master_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] i_req_valid,
   input  logic             i_last_grant,
   output logic             o_grant_idx_c,
   output logic             o_grant_valid_c
);

   always_comb begin
      o_grant_valid_c = |i_req_valid;
      o_grant_idx_c   = 1'b0;
      if (&i_req_valid) begin
         o_grant_idx_c = ~i_last_grant;
      end else if (i_req_valid[1]) begin
         o_grant_idx_c = 1'b1;
      end
   end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// Shares one AXI4-Lite master port between fetch (port 0) and load/store (port 1),
// one transaction at a time; all bus and completion outputs decode from registers.
module axi4_lite_master_arbiter
   import axi4_lite_master_arbiter_pkg::*;
#(
   parameter  int unsigned ADDR_W = 32,
   parameter  int unsigned DATA_W = 32,
   localparam int unsigned STRB_W = DATA_W / 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ-1:0]              req_write,
   input  logic [N_REQ-1:0][ADDR_W-1:0]  req_addr,
   input  logic [N_REQ-1:0][DATA_W-1:0]  req_wdata,
   input  logic [N_REQ-1:0][STRB_W-1:0]  req_wstrb,
   output logic [N_REQ-1:0]              req_done,
   output logic [DATA_W-1:0]             req_rdata,
   output logic [1:0]                    req_resp,
   output logic [ADDR_W-1:0]             m_awaddr,
   output logic                          m_awvalid,
   input  logic                          m_awready,
   output logic [DATA_W-1:0]             m_wdata,
   output logic [STRB_W-1:0]             m_wstrb,
   output logic                          m_wvalid,
   input  logic                          m_wready,
   input  logic [1:0]                    m_bresp,
   input  logic                          m_bvalid,
   output logic                          m_bready,
   output logic [ADDR_W-1:0]             m_araddr,
   output logic                          m_arvalid,
   input  logic                          m_arready,
   input  logic [DATA_W-1:0]             m_rdata,
   input  logic [1:0]                    m_rresp,
   input  logic                          m_rvalid,
   output logic                          m_rready
);

   arb_state_e          r_state;
   arb_state_e          w_state_nxt;
   logic                r_grant;
   logic                r_last_grant;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [STRB_W-1:0]   r_wstrb;
   logic [DATA_W-1:0]   r_rdata;
   axi_resp_e           r_resp;
   logic                r_aw_done;
   logic                r_w_done;
   logic                w_grant_idx;
   logic                w_grant_valid;

   rr_arbiter2 u_rr_arbiter2 (
      .i_req_valid     (req_valid),
      .i_last_grant    (r_last_grant),
      .o_grant_idx_c   (w_grant_idx),
      .o_grant_valid_c (w_grant_valid)
   );

   assign m_araddr  = r_addr;
   assign m_awaddr  = r_addr;
   assign m_wdata   = r_wdata;
   assign m_wstrb   = r_wstrb;
   assign req_rdata = r_rdata;
   assign req_resp  = r_resp;

   // State register plus the per-transaction data captured along the way.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wstrb      <= '0;
         r_rdata      <= '0;
         r_resp       <= RESP_OKAY;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_valid) begin
                  r_grant      <= w_grant_idx;
                  r_last_grant <= w_grant_idx;
                  r_addr       <= req_addr[w_grant_idx];
                  r_wdata      <= req_wdata[w_grant_idx];
                  r_wstrb      <= req_wstrb[w_grant_idx];
                  r_aw_done    <= 1'b0;
                  r_w_done     <= 1'b0;
               end
            end
            ST_AW_W: begin
               if (m_awready) r_aw_done <= 1'b1;
               if (m_wready)  r_w_done  <= 1'b1;
            end
            ST_R: begin
               if (m_rvalid) begin
                  r_rdata <= m_rdata;
                  r_resp  <= axi_resp_e'(m_rresp);
               end
            end
            ST_B: begin
               if (m_bvalid) begin
                  r_rdata <= '0;
                  r_resp  <= axi_resp_e'(m_bresp);
               end
            end
            default: ;
         endcase
      end
   end

   // Next state and state-decoded channel/completion outputs.
   always_comb begin
      w_state_nxt = r_state;
      m_arvalid   = 1'b0;
      m_awvalid   = 1'b0;
      m_wvalid    = 1'b0;
      m_rready    = 1'b0;
      m_bready    = 1'b0;
      req_done    = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_grant_valid) begin
               w_state_nxt = req_write[w_grant_idx] ? ST_AW_W : ST_AR;
            end
         end
         ST_AR: begin
            m_arvalid = 1'b1;
            if (m_arready) w_state_nxt = ST_R;
         end
         ST_R: begin
            m_rready = 1'b1;
            if (m_rvalid) w_state_nxt = ST_RESP;
         end
         ST_AW_W: begin
            m_awvalid = ~r_aw_done;
            m_wvalid  = ~r_w_done;
            // While a channel is still pending its valid is high, so ready alone is the handshake.
            if ((r_aw_done || m_awready) && (r_w_done || m_wready)) begin
               w_state_nxt = ST_B;
            end
         end
         ST_B: begin
            m_bready = 1'b1;
            if (m_bvalid) w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            req_done[r_grant] = 1'b1;
            w_state_nxt       = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// Directed bench for axi4_lite_master_arbiter: vector table plus multi-cycle corner sequences.
module tb_axi4_lite_master_arbiter;
   import axi4_lite_master_arbiter_pkg::*;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [1:0]               req_valid;
   logic [1:0]               req_write;
   logic [1:0][ADDR_W-1:0]   req_addr;
   logic [1:0][DATA_W-1:0]   req_wdata;
   logic [1:0][STRB_W-1:0]   req_wstrb;
   logic [1:0]               req_done;
   logic [DATA_W-1:0]        req_rdata;
   logic [1:0]               req_resp;
   logic [ADDR_W-1:0]        m_awaddr;
   logic                     m_awvalid, m_awready;
   logic [DATA_W-1:0]        m_wdata;
   logic [STRB_W-1:0]        m_wstrb;
   logic                     m_wvalid, m_wready;
   logic [1:0]               m_bresp;
   logic                     m_bvalid, m_bready;
   logic [ADDR_W-1:0]        m_araddr;
   logic                     m_arvalid, m_arready;
   logic [DATA_W-1:0]        m_rdata;
   logic [1:0]               m_rresp;
   logic                     m_rvalid, m_rready;

   always #5 clk = ~clk;

   axi4_lite_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .req_done(req_done), .req_rdata(req_rdata), .req_resp(req_resp),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
   );

   typedef struct {
      logic        wr;
      int          port;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          ar_lat, aw_lat, w_lat, r_lat, b_lat;
      logic [31:0] sl_rdata;
      logic [1:0]  sl_resp;
      logic [1:0]  exp_done;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_resp;
      int          exp_lat;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;

   // Slave behaviour knobs and bus observations
   int          ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
   logic [31:0] sl_rdata = '0;
   logic [1:0]  sl_rresp = '0, sl_bresp = '0;
   int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
   int          ar_cyc = 0, aw_cyc = 0, w_cyc = 0;
   logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
   logic [3:0]  cap_wstrb = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   task automatic fail_timeout(input string name);
      n_checks++;
      $display("FAIL %s: actual no event required event within budget", name);
   endtask

   task automatic wait_done(input int budget, output logic [1:0] done, output int n);
      n = 0;
      done = 2'b00;
      while (done == 2'b00 && n < budget) begin
         @(negedge clk);
         n++;
         done = req_done;
      end
   endtask

   // Slave model and bus monitor: decides readies/valids at each negedge from the knobs.
   initial begin
      m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      m_rvalid  = 1'b0; m_rdata   = '0;   m_rresp  = '0;
      m_bvalid  = 1'b0; m_bresp   = '0;
      forever begin
         @(negedge clk);
         if (req_done !== 2'b00) check("done_onehot", 32'($onehot(req_done)), 32'd1);
         if (m_arvalid) begin
            ar_cyc++;
            m_arready = (ar_cnt == ar_lat);
            if (m_arready) cap_araddr = m_araddr;
            ar_cnt++;
         end else begin
            m_arready = 1'b0; ar_cnt = 0;
         end
         if (m_awvalid) begin
            aw_cyc++;
            m_awready = (aw_cnt == aw_lat);
            if (m_awready) cap_awaddr = m_awaddr;
            aw_cnt++;
         end else begin
            m_awready = 1'b0; aw_cnt = 0;
         end
         if (m_wvalid) begin
            w_cyc++;
            m_wready = (w_cnt == w_lat);
            if (m_wready) begin cap_wdata = m_wdata; cap_wstrb = m_wstrb; end
            w_cnt++;
         end else begin
            m_wready = 1'b0; w_cnt = 0;
         end
         if (m_rready) begin
            m_rvalid = (r_cnt == r_lat);
            m_rdata  = m_rvalid ? sl_rdata : 32'h0;
            m_rresp  = sl_rresp;
            r_cnt++;
         end else begin
            m_rvalid = 1'b0; r_cnt = 0;
         end
         if (m_bready) begin
            m_bvalid = (b_cnt == b_lat);
            m_bresp  = sl_bresp;
            b_cnt++;
         end else begin
            m_bvalid = 1'b0; b_cnt = 0;
         end
      end
   end

   // Issue one request from a table entry (called at an IDLE negedge) and check its completion.
   task automatic run_vec(input vec_t v, input string tag);
      logic [1:0] done;
      int         n;
      ar_lat = v.ar_lat; aw_lat = v.aw_lat; w_lat = v.w_lat; r_lat = v.r_lat; b_lat = v.b_lat;
      sl_rdata = v.sl_rdata; sl_rresp = v.sl_resp; sl_bresp = v.sl_resp;
      ar_cyc = 0; aw_cyc = 0; w_cyc = 0;
      cap_araddr = '0; cap_awaddr = '0; cap_wdata = '0; cap_wstrb = '0;
      req_valid[v.port] = 1'b1;
      req_write[v.port] = v.wr;
      req_addr[v.port]  = v.addr;
      req_wdata[v.port] = v.wdata;
      req_wstrb[v.port] = v.wstrb;
      wait_done(200, done, n);
      if (done == 2'b00) begin
         fail_timeout({tag, "_done"});
      end else begin
         check({tag, "_done"},    32'(done),      32'(v.exp_done));
         check({tag, "_rdata"},   req_rdata,      v.exp_rdata);
         check({tag, "_resp"},    32'(req_resp),  32'(v.exp_resp));
         check({tag, "_latency"}, 32'(n),         32'(v.exp_lat));
         if (v.wr) begin
            check({tag, "_awaddr"},   cap_awaddr,   v.addr);
            check({tag, "_wdata"},    cap_wdata,    v.wdata);
            check({tag, "_wstrb"},    32'(cap_wstrb), 32'(v.wstrb));
            check({tag, "_awv_cyc"},  32'(aw_cyc),  32'(v.aw_lat + 1));
            check({tag, "_wv_cyc"},   32'(w_cyc),   32'(v.w_lat + 1));
            check({tag, "_arv_cyc"},  32'(ar_cyc),  32'd0);
         end else begin
            check({tag, "_araddr"},   cap_araddr,   v.addr);
            check({tag, "_arv_cyc"},  32'(ar_cyc),  32'(v.ar_lat + 1));
            check({tag, "_awv_cyc"},  32'(aw_cyc),  32'd0);
         end
      end
      req_valid[v.port] = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [31:0] bus_ctl();
      return {27'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready};
   endfunction

   vec_t vecs[7];
   vec_t v_post;

   initial begin
      logic [1:0] done;
      int         n;
      bit         seen;

      vecs[0] = '{wr:1'b0, port:0, addr:32'h0000_1000, wdata:32'h0, wstrb:4'h0,
                  ar_lat:0, aw_lat:0, w_lat:0, r_lat:0, b_lat:0,
                  sl_rdata:32'hDEAD_BEEF, sl_resp:2'b00,
                  exp_done:2'b01, exp_rdata:32'hDEAD_BEEF, exp_resp:2'b00, exp_lat:3};
      vecs[1] = '{wr:1'b1, port:1, addr:32'h0000_2004, wdata:32'h1234_5678, wstrb:4'b0011,
                  ar_lat:0, aw_lat:3, w_lat:0, r_lat:0, b_lat:0,
                  sl_rdata:32'h0, sl_resp:2'b00,
                  exp_done:2'b10, exp_rdata:32'h0, exp_resp:2'b00, exp_lat:6};
      vecs[2] = '{wr:1'b0, port:1, addr:32'h0000_3008, wdata:32'h0, wstrb:4'h0,
                  ar_lat:0, aw_lat:0, w_lat:0, r_lat:0, b_lat:0,
                  sl_rdata:32'hCAFE_0001, sl_resp:2'b10,
                  exp_done:2'b10, exp_rdata:32'hCAFE_0001, exp_resp:2'b10, exp_lat:3};
      vecs[3] = '{wr:1'b1, port:0, addr:32'h0000_400C, wdata:32'hA5A5_A5A5, wstrb:4'b1111,
                  ar_lat:0, aw_lat:0, w_lat:0, r_lat:0, b_lat:0,
                  sl_rdata:32'h0, sl_resp:2'b11,
                  exp_done:2'b01, exp_rdata:32'h0, exp_resp:2'b11, exp_lat:3};
      vecs[4] = '{wr:1'b0, port:0, addr:32'h0000_5010, wdata:32'h0, wstrb:4'h0,
                  ar_lat:2, aw_lat:0, w_lat:0, r_lat:1, b_lat:0,
                  sl_rdata:32'h0BAD_F00D, sl_resp:2'b01,
                  exp_done:2'b01, exp_rdata:32'h0BAD_F00D, exp_resp:2'b01, exp_lat:6};
      vecs[5] = '{wr:1'b1, port:1, addr:32'h0000_6014, wdata:32'h55AA_55AA, wstrb:4'b1100,
                  ar_lat:0, aw_lat:0, w_lat:2, r_lat:0, b_lat:1,
                  sl_rdata:32'h0, sl_resp:2'b00,
                  exp_done:2'b10, exp_rdata:32'h0, exp_resp:2'b00, exp_lat:6};
      vecs[6] = '{wr:1'b1, port:0, addr:32'h0000_7018, wdata:32'h0102_0304, wstrb:4'b1000,
                  ar_lat:0, aw_lat:1, w_lat:1, r_lat:0, b_lat:0,
                  sl_rdata:32'h0, sl_resp:2'b10,
                  exp_done:2'b01, exp_rdata:32'h0, exp_resp:2'b10, exp_lat:4};
      v_post  = '{wr:1'b0, port:1, addr:32'h0000_9000, wdata:32'h0, wstrb:4'h0,
                  ar_lat:0, aw_lat:0, w_lat:0, r_lat:0, b_lat:0,
                  sl_rdata:32'h600D_CAFE, sl_resp:2'b00,
                  exp_done:2'b10, exp_rdata:32'h600D_CAFE, exp_resp:2'b00, exp_lat:3};

      reset = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_bus_ctl", bus_ctl(),        32'd0);
      check("rst_done",    32'(req_done),    32'd0);
      check("rst_rdata",   req_rdata,        32'd0);
      check("rst_resp",    32'(req_resp),    32'd0);

      // Both ports read back-to-back: grants must alternate starting with port 0.
      req_valid = 2'b11; req_write = 2'b00;
      req_addr[0] = 32'h0000_0100; req_addr[1] = 32'h0000_0200;
      sl_rdata = 32'h1111_0000; sl_rresp = 2'b00;
      for (int k = 0; k < 6; k++) begin
         wait_done(50, done, n);
         if (done == 2'b00) fail_timeout($sformatf("rr_done%0d", k));
         else check($sformatf("rr_grant%0d", k), 32'(done), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      req_valid = 2'b00;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Reset asserted while the read data phase is waiting on the slave.
      r_lat = 50; ar_lat = 0;
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h0000_8000;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = m_rready;
      end
      if (!seen) fail_timeout("rst_mid_rready");
      reset = 1'b1;
      req_valid = 2'b00;
      @(negedge clk);
      check("rst_mid_bus_ctl", bus_ctl(),     32'd0);
      check("rst_mid_done",    32'(req_done), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_idle_done", 32'(req_done), 32'd0);
      run_vec(v_post, "post_rst");

      // Port 0 read stalls in R; port 1 must wait until the next IDLE after port 0 completes.
      ar_lat = 0; r_lat = 10; sl_rdata = 32'h1111_2222; sl_rresp = 2'b00;
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h0000_A000;
      @(negedge clk);
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h0000_B000;
      wait_done(40, done, n);
      if (done == 2'b00) begin
         fail_timeout("stall_p0_done");
      end else begin
         check("stall_p0_done",  32'(done),  32'd1);
         check("stall_p0_rdata", req_rdata,  32'h1111_2222);
      end
      req_valid[0] = 1'b0;
      r_lat = 0; sl_rdata = 32'h3333_4444;
      @(negedge clk);
      check("stall_idle_arvalid", 32'(m_arvalid), 32'd0);
      @(negedge clk);
      check("stall_p1_arvalid", 32'(m_arvalid), 32'd1);
      check("stall_p1_araddr",  m_araddr,       32'h0000_B000);
      wait_done(20, done, n);
      if (done == 2'b00) begin
         fail_timeout("stall_p1_done");
      end else begin
         check("stall_p1_done",  32'(done), 32'd2);
         check("stall_p1_rdata", req_rdata, 32'h3333_4444);
      end
      req_valid = 2'b00;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi4_lite_master_arbiter.md
Name: axi4_lite_master_arbiter

Overview:
- Shares one AXI4-Lite master port between two simple requesters: port 0 = instruction fetch, port 1 = load/store unit.
- Arbitrates round-robin, converts the winner's request into AXI4-Lite channel handshakes, and returns the data and response code to that requester only.
- One transaction outstanding at a time. Sits between the core and the system interconnect.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; STRB_W = DATA_W/8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  [2]  request pending, per requester; held until req_done
- req_write  in  [2]  1 = write, 0 = read
- req_addr  in  [2][ADDR_W]  byte address
- req_wdata  in  [2][DATA_W]  write data
- req_wstrb  in  [2][STRB_W]  write byte strobes
- req_done  out  [2]  one-cycle completion pulse, one-hot to the owner
- req_rdata  out  [DATA_W]  read data; valid while req_done is high
- req_resp  out  [2]  response code (AXI4-Lite read/write response type); valid with req_done
- m_awaddr, m_awvalid, m_awready  out/out/in  ADDR_W/1/1  write address channel
- m_wdata, m_wstrb, m_wvalid, m_wready  out/out/out/in  DATA_W/STRB_W/1/1  write data channel
- m_bresp, m_bvalid, m_bready  in/in/out  2/1/1  write response channel
- m_araddr, m_arvalid, m_arready  out/out/in  ADDR_W/1/1  read address channel
- m_rdata, m_rresp, m_rvalid, m_rready  in/in/in/out  DATA_W/2/1/1  read data channel

Behaviour:
- Reset values: all m_*valid and m_*ready outputs = 0; req_done = 0; req_rdata = 0; req_resp = OKAY; state = IDLE; last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, AR, R, AW_W, B, RESP.
- IDLE:
  - If any req_valid, pick a winner: the only requester, or on a tie the one not equal to last_grant.
  - Register grant, addr, wdata, wstrb and write.
  - Next state: AW_W if write, else AR. last_grant is updated on grant.
- AR:
  - m_arvalid = 1, m_araddr = latched addr.
  - Leave for R on m_arready.
- R:
  - m_rready = 1.
  - On m_rvalid: capture rdata and rresp, go to RESP.
- AW_W:
  - m_awvalid and m_wvalid both asserted from entry.
  - Each drops independently after its own ready handshake and stays low.
  - Go to B when both handshakes are done; they may land in the same cycle or in either order.
- B:
  - m_bready = 1.
  - On m_bvalid: capture bresp, set req_rdata = 0, go to RESP.
- RESP:
  - req_done[grant] = 1 for exactly one cycle; req_rdata and req_resp are stable in that cycle.
  - Next state is IDLE; the next arbitration happens in IDLE.
- Requester contract:
  - Drop or replace req_valid in the cycle after req_done.
  - Fields must be stable while valid. Latching makes later changes harmless.
- All master-side and req_done outputs are driven from registers or state decode, not from combinational paths through the m_*ready inputs.
- Minimum latency with an always-ready slave:
  - Read: valid seen in cycle 0 (IDLE) → AR in cycle 1 → R in cycle 2; with rvalid in cycle 2, req_done in cycle 3. Four cycles total.
  - Write: AW_W in cycle 1 → B in cycle 2 → req_done in cycle 3.
- Response codes are passed through unchanged: OKAY, EXOKAY, SLVERR, DECERR. Only OKAY counts as success to the requesters.
- The losing requester is not touched: its req_done stays 0 and its request stays pending.
- Reset mid-transaction: all valid/ready outputs drop on the next edge and no req_done is issued. The in-flight bus transaction is abandoned; the system resets the slave together with this block.
- A deasserted req_valid after grant is ignored; the latched transaction still completes and req_done still pulses.

Decomposition:
- Shared package (existing AXI4-Lite constants package): read and write response enum types.
- Add to the same package: the FSM state enum (ArbState) and the requester count constant N_REQ = 2.
- Sub-module rr_arbiter2: combinational round-robin pick from req_valid and last_grant. It outputs the grant index and a grant-valid flag.

Test Plan:
- Single read, port 0, addr 0x0000_1000; slave ready every cycle, returns rdata 0xDEAD_BEEF, rresp OKAY → req_done = 2'b01 in cycle 3, req_rdata = 0xDEAD_BEEF, req_resp = OKAY; m_arvalid high only in cycle 1.
- Write, port 1, addr 0x0000_2004, wdata 0x1234_5678, wstrb 4'b0011; awready delayed 3 cycles, wready immediate → m_wvalid drops after 1 cycle; m_awvalid is held until its handshake; then B; req_done = 2'b10 with req_resp = OKAY.
- Both ports request reads continuously, 6 transactions → grants alternate 0,1,0,1,0,1; no req_done is ever 2'b11.
- Read returns rresp SLVERR; a following write returns bresp DECERR → req_resp = 2'b10, then 2'b11, each delivered with the matching req_done.
- Assert reset while in R with m_rready high → the next cycle has all m_*valid and m_*ready = 0 and req_done = 0; then a fresh port-1 request completes normally.
- Slave stalls rvalid for 10 cycles while port 1 asserts req_valid → port 1 is not granted until port 0's RESP cycle has passed; port 1's grant then occurs in the next IDLE.
